// File: rtl/seq_mul_arbiter.sv
// Round-robin front end for a shared sequential signed multiplier core.
// Accepts one request at a time, pulses the core, waits out its latency, returns a tagged product.
module seq_mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 32,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_result,
  input  logic                     rsp_ready,
  output logic                     mul_load,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_result,
  output logic                     busy,
  output logic [15:0]              ops_done
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  // Handshakes: a request transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; the response transfers on an edge where
  // rsp_valid and rsp_ready are both high. Neither valid may depend on ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       ops_cnt;
  logic              accept;
  logic              rsp_fire;
  logic [ID_W-1:0]   rr_next;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // Gated by reset so no grant is visible while reset is held.
  assign accept    = (state == ST_IDLE) && found && !reset;
  assign req_ready = accept ? (N_REQ'(1) << win_id) : '0;
  assign rsp_fire  = (state == ST_RESP) && rsp_ready;
  assign rr_next   = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      cnt        <= '0;
      ops_cnt    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        mul_a  <= req_a[win_id*WIDTH +: WIDTH];
        mul_b  <= req_b[win_id*WIDTH +: WIDTH];
        rsp_id <= win_id;
      end
      if (state == ST_LOAD) cnt <= CNT_W'(MUL_LATENCY - 1);
      // The core result is valid on the edge where the countdown reaches zero.
      if (state == ST_BUSY) begin
        if (cnt == '0) rsp_result <= mul_result;
        else           cnt        <= cnt - CNT_W'(1);
      end
      if (rsp_fire) begin
        rr_ptr  <= rr_next;
        ops_cnt <= ops_cnt + 16'd1;
      end
    end
  end

  assign mul_load  = (state == ST_LOAD);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign ops_done  = ops_cnt;

endmodule

// File: tb/tb_seq_mul_arbiter.sv
// Bench for seq_mul_arbiter: models the multiplier core, drives directed requests,
// and scores tagged responses against hand-computed products.
module tb_seq_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int L   = 32;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*W-1:0]    req_a = '0;
  logic [N*W-1:0]    req_b = '0;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_result;
  logic              rsp_ready = 1'b1;
  logic              mul_load;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_result;
  logic              busy;
  logic [15:0]       ops_done;

  seq_mul_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ready(rsp_ready),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .busy(busy), .ops_done(ops_done)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // scoreboard queue: {id, product}
  logic [IDW+63:0] exp_q[$];

  // multiplier core model: product is only correct in the cycle the controller must sample it
  logic              trk = 1'b0;
  int                load_cyc = 0;
  logic signed [63:0] prod = '0;
  assign mul_result = (trk && cyc == load_cyc + L) ? prod : ~prod;

  // monitor
  int          t_acc = 0;
  int          hs_cyc = 0;
  logic [31:0] acc_a = '0;
  logic [31:0] acc_b = '0;
  logic        rsp_seen = 1'b0;
  logic [IDW-1:0] hold_id = '0;
  logic [63:0] hold_res = '0;
  logic [15:0] exp_ops = '0;
  logic        ops_preload = 1'b0;
  logic [IDW+63:0] e;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_ctrl", {req_ready, rsp_valid, mul_load, busy, rsp_id, ops_done}, '0);
      chk("reset_data", {rsp_result, mul_a, mul_b}, '0);
      exp_ops  = '0;
      trk      = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      if (ops_preload) exp_ops = 16'hffff;
      chk("ready_subset", req_ready & ~req_valid, '0);
      if (busy) chk("ready_busy", req_ready, '0);
      if (|(req_valid & req_ready)) begin
        chk("grant_onehot", $countones(req_ready), 1);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            acc_a = req_a[i*W +: W];
            acc_b = req_b[i*W +: W];
          end
        end
        t_acc = cyc;
      end
      if (mul_load) begin
        chk("load_cycle", cyc, t_acc + 1);
        chk("load_ops", {mul_a, mul_b}, {acc_a, acc_b});
        trk      = 1'b1;
        load_cyc = cyc;
        prod     = $signed(mul_a) * $signed(mul_b);
      end else if (trk && !rsp_valid) begin
        chk("ops_stable", {mul_a, mul_b}, {acc_a, acc_b});
      end
      if (rsp_valid && !rsp_seen) begin
        chk("rsp_cycle", cyc, t_acc + 2 + L);
        rsp_seen = 1'b1;
        trk      = 1'b0;
        hold_id  = rsp_id;
        hold_res = rsp_result;
      end else if (rsp_valid) begin
        chk("rsp_hold", {rsp_id, rsp_result}, {hold_id, hold_res});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {rsp_id, rsp_result}, '1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e[IDW+63:64]);
          chk("rsp_result", rsp_result, e[63:0]);
        end
        chk("ops_done", ops_done, exp_ops);
        exp_ops  = exp_ops + 16'd1;
        rsp_seen = 1'b0;
        hs_cyc   = cyc;
      end
    end
  end

  // driver tasks
  task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b, input logic [63:0] r);
    req_valid[i]    = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    exp_q.push_back({IDW'(i), r});
  endtask

  task automatic wait_grant(input int i, output int t);
    bit got = 0;
    t = -1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1;
        t   = cyc;
      end
    end
    if (!got) chk("grant_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int a_tab[4] = '{-15, -17, 0, 3672};
  int b_tab[4] = '{20, -17, 64, 9648};
  longint r_tab[4] = '{-300, 289, 0, 35427456};

  initial begin
    int t;
    int t0;
    bit seen;
    // contention: 0 and 2 valid from reset
    raise(0, 1, 40, 40);
    raise(2, 36, 42, 1512);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_grant(0, t);
    raise(0, 5, 7, 35);
    wait_grant(2, t);
    wait_grant(0, t);
    wait_idle();

    // single request
    t0 = cyc;
    raise(0, 35, 96, 3360);
    wait_grant(0, t);
    chk("accept_same_cycle", t, t0);
    wait_idle();

    // signed sequential
    for (int k = 0; k < 4; k++) begin
      raise(1, a_tab[k], b_tab[k], r_tab[k]);
      wait_grant(1, t);
      wait_idle();
    end

    // backpressure, with requester 1 waiting behind it
    rsp_ready = 1'b0;
    raise(3, 12, -5, -60);
    wait_grant(3, t);
    raise(1, 2, 3, 6);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    if (!seen) chk("rsp_timeout", 0, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(1, t);
    chk("accept_after_hs", t, hs_cyc + 1);
    wait_idle();

    // extremes, both on requester 2 so rr_ptr ends at 3
    raise(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_grant(2, t);
    wait_idle();
    raise(2, 32'h7fff_ffff, 32'h8000_0000, 64'hc000_0000_8000_0000);
    wait_grant(2, t);
    wait_idle();

    // reset ten cycles into BUSY
    raise(0, 7, 9, 63);
    wait_grant(0, t);
    repeat (11) @(posedge clk);
    #1 chk("busy_before_reset", busy, 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_reset_ctrl", {req_ready, rsp_valid, mul_load, busy, rsp_id, ops_done}, '0);
    chk("async_reset_data", {rsp_result, mul_a, mul_b}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    raise(1, 165, 348, 57420);
    raise(3, -4, 25, -100);
    wait_grant(1, t);
    wait_grant(3, t);
    wait_idle();

    // ops_done wrap
    force dut.ops_cnt = 16'hffff;
    ops_preload = 1'b1;
    @(negedge clk);
    #1 ops_preload = 1'b0;
    @(posedge clk);
    #1 release dut.ops_cnt;
    raise(0, -1, -1, 1);
    wait_grant(0, t);
    wait_idle();
    chk("ops_wrap", ops_done, 16'd0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mul_arbiter.md
# seq_mul_arbiter

Controller that shares one sequential signed multiplier core among `N_REQ` requesters. It arbitrates round-robin and latches the winner's operands. It drives the core with a one-cycle load pulse and times the core's fixed latency with a counter. It then returns the 64-bit product on a single tagged response channel. It sits between the requesting datapath blocks and the `seq_multiplier` core, which holds no handshake of its own.

## Interface
- `N_REQ`, 4: number of requesters, at least 2. `ID_W` = ceil(log2(N_REQ)), minimum 1 (localparam).
- `WIDTH`, 32: operand width; product width is 2*WIDTH.
- `MUL_LATENCY`, 32: cycles from the load edge to a valid core result.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in N_REQ: per-requester request.
- `req_a`, `req_b` in N_REQ*WIDTH: packed signed operands; requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready` out N_REQ: one-hot accept, combinational, asserted only in IDLE.
- `rsp_valid` out 1: response valid.
- `rsp_id` out ID_W: index of the requester being answered.
- `rsp_result` out 2*WIDTH: signed product.
- `rsp_ready` in 1: response consumer ready.
- `mul_load` out 1: one-cycle pulse that starts the core.
- `mul_a`, `mul_b` out WIDTH: operands to the core; held stable from LOAD through BUSY.
- `mul_result` in 2*WIDTH: core product.
- `busy` out 1: high in any state other than IDLE.
- `ops_done` out 16: count of completed response handshakes; wraps at 65535 to 0.

## Operation
- FSM states: IDLE, LOAD, BUSY, RESP.
- **IDLE**
  - Search starts at round-robin pointer `rr_ptr`: the first i in the order rr_ptr, rr_ptr+1, … (mod N_REQ) with `req_valid[i]` = 1 wins.
  - `req_ready[win]` = 1 in the same cycle; the handshake completes in that cycle.
  - On that edge: latch `req_a[win]`, `req_b[win]` into `mul_a`/`mul_b`, latch `win` into `rsp_id`, then go to LOAD.
  - With no valid request, stay in IDLE.
- **LOAD**: `mul_load` = 1 for exactly one cycle; counter ← MUL_LATENCY−1; go to BUSY.
- **BUSY**
  - Counter decrements each cycle.
  - On the edge where counter = 0: `rsp_result` ← `mul_result`, go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_id` and `rsp_result` are held stable until `rsp_ready`.
  - On the handshake edge: `rr_ptr` ← (rsp_id+1) mod N_REQ, `ops_done` += 1, go to IDLE.
- Only one operation is in flight. Requests arriving outside IDLE wait; `req_ready` stays 0.
- Requesters must hold `req_valid` and operands until `req_ready`. A `req_valid` that drops before grant is simply not selected.
- Arithmetic is signed two's complement, WIDTH×WIDTH → 2*WIDTH, computed by the core. This block passes values through unmodified.

## Timing
- **Reset values**: state IDLE, `rr_ptr` 0, counter 0, `ops_done` 0, `mul_a`/`mul_b`/`rsp_result`/`rsp_id` 0, `mul_load` 0, `rsp_valid` 0, `busy` 0, `req_ready` 0 while reset is asserted.
- **Latency**
  - Accept in cycle T, LOAD in T+1.
  - BUSY spans cycles T+2 through T+1+MUL_LATENCY.
  - `mul_result` is sampled exactly MUL_LATENCY edges after the load edge.
  - `rsp_valid` rises in cycle T+2+MUL_LATENCY.
  - With `rsp_ready` = 1, the next accept is possible in T+3+MUL_LATENCY, giving a minimum issue interval of MUL_LATENCY+3 cycles.
- **Backpressure**: `rsp_valid` held with constant data for any number of cycles; no new accept until the handshake.
- **Reset mid-operation**: in LOAD, BUSY or RESP, the in-flight operation is discarded and the FSM returns to IDLE with the reset values above. `ops_done` is not incremented.
- **Simultaneous requests**: priority is determined solely by `rr_ptr`. A requester with continuously asserted `req_valid` is served within N_REQ operations.

## Test plan
- **Single request**: requester 0 sends a=35, b=96 → `req_ready[0]` in the same cycle; `mul_load` one cycle later; `rsp_valid` at T+34 with `rsp_result` = 3360, `rsp_id` = 0, `ops_done` = 1.
- **Signed operands, sequential requests**: a=−15, b=20 → −300; a=−17, b=−17 → 289; a=0, b=64 → 0; a=3672, b=9648 → 35427456. `mul_a`/`mul_b` stay stable for all BUSY cycles.
- **Contention**: requesters 0 and 2 both valid from reset, with a=1, b=40 and a=36, b=42 → 0 served first (result 40, id 0), then 2 (result 1512, id 2). Then, with 0 and 2 asserting again, 0 is not served before 2 completes under `rr_ptr` = 1.
- **Backpressure**: hold `rsp_ready` = 0 for 10 cycles after `rsp_valid` → `rsp_result` and `rsp_id` remain constant; `req_ready` stays 0; the accept happens the cycle after the handshake.
- **Reset mid-BUSY**: assert reset 10 cycles into BUSY → all outputs return to 0 immediately; the next request (165×348) completes with 57420 and `rsp_id` equal to the winner from `rr_ptr` = 0.
- **Extremes and wrap**: a=b=−2^31 → 2^62; preload `ops_done` via 65536 handshakes (or a forced value) → wraps to 0.
